child_result_reducer: RTL and testbench

//  Sits between the child-core array and the parent core in the multicore top level.

---
 rtl/child_result_reducer_pkg.sv | 20 ++
 rtl/child_result_reducer_slot.sv | 73 +++++++
 rtl/child_result_reducer.sv | 153 +++++++++++++++
 tb/tb_child_result_reducer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/child_result_reducer_pkg.sv
// ---------------------------------------------------------------------------
// multicore_pkg
// Shared defaults for the multicore top level: child count, data width,
// core-index width and the reducer FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package multicore_pkg;

  localparam int NUM_CORES_DEF = 31;
  localparam int DATA_W_DEF    = 32;
  localparam int IDX_W_DEF     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DONE  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

endpackage

// File: rtl/child_result_reducer_slot.sv
// ---------------------------------------------------------------------------
// result_slot
// One capture slot for a child core. Detects the rising edge of the child's
// buf_flag and latches its (val_1, val_2) pair once per round; later edges
// are ignored until the slot is cleared.
// Ports:
//   Clk      in   clock, rising edge
//   Reset    in   asynchronous active-low reset
//   flag     in   child buf_flag
//   v1, v2   in   child buf_val_1 / buf_val_2
//   clr      in   clear the captured bit (end of round)
//   captured out  slot holds an unconsumed capture
//   q1, q2   out  latched values
// ---------------------------------------------------------------------------
module result_slot
  import multicore_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              flag,
  input  logic [DATA_W-1:0] v1,
  input  logic [DATA_W-1:0] v2,
  input  logic              clr,
  output logic              captured,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2
);

  logic              prev_q;
  logic              cap_q, cap_d;
  logic [DATA_W-1:0] q1_q, q1_d;
  logic [DATA_W-1:0] q2_q, q2_d;
  logic              rise;
  logic              load;

  assign rise = flag & ~prev_q;
  // A rise during the clear cycle starts the next round, so set beats clear.
  assign load = rise & (~cap_q | clr);

  always_comb begin
    cap_d = cap_q;
    q1_d  = q1_q;
    q2_d  = q2_q;
    if (load) begin
      cap_d = 1'b1;
      q1_d  = v1;
      q2_d  = v2;
    end else if (clr) begin
      cap_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prev_q <= 1'b0;
      cap_q  <= 1'b0;
      q1_q   <= '0;
      q2_q   <= '0;
    end else begin
      prev_q <= flag;
      cap_q  <= cap_d;
      q1_q   <= q1_d;
      q2_q   <= q2_d;
    end
  end

  assign captured = cap_q;
  assign q1       = q1_q;
  assign q2       = q2_q;

endmodule

// File: rtl/child_result_reducer.sv
// ---------------------------------------------------------------------------
// child_result_reducer
// Collects one (val_1, val_2) pair from every child core, then scans the
// slots one per cycle and presents the minimum unsigned val_1 (ties keep the
// lowest core index) with its val_2 and index to the parent core.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | collecting captures; leave when every slot is captured
//   ST_SCAN  | compare slot k against best, k = 0 .. NUM_CORES-1
//   ST_DONE  | result_valid high, best_* held, wait for ack
//   ST_CLEAR | drop all captured bits, result_valid low, back to idle
//
// Ports:
//   Clk, Reset     clock / asynchronous active-low reset
//   core_flag      per-child buf_flag, bit i = core i
//   core_val_1/2   flattened child values, core i at [i*DATA_W +: DATA_W]
//   ack            parent consumed the result (honoured only in ST_DONE)
//   best_val_1/2   winning values
//   best_idx       winning core index
//   result_valid   best_* valid
//   busy           high during the scan cycles
//   captured_mask  slot i holds an unconsumed capture
// ---------------------------------------------------------------------------
module child_result_reducer
  import multicore_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [NUM_CORES-1:0]        core_flag,
  input  logic [NUM_CORES*DATA_W-1:0] core_val_1,
  input  logic [NUM_CORES*DATA_W-1:0] core_val_2,
  input  logic                        ack,
  output logic [DATA_W-1:0]           best_val_1,
  output logic [DATA_W-1:0]           best_val_2,
  output logic [IDX_W-1:0]            best_idx,
  output logic                        result_valid,
  output logic                        busy,
  output logic [NUM_CORES-1:0]        captured_mask
);

  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_CORES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [DATA_W-1:0] best_v1_q, best_v1_d;
  logic [DATA_W-1:0] best_v2_q, best_v2_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [NUM_CORES-1:0] captured;
  logic [DATA_W-1:0]    slot_q1 [NUM_CORES];
  logic [DATA_W-1:0]    slot_q2 [NUM_CORES];
  logic                 clr;
  logic [DATA_W-1:0]    sel_v1;
  logic [DATA_W-1:0]    sel_v2;
  logic                 take;

  assign clr = (state_q == ST_CLEAR);

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    result_slot #(.DATA_W(DATA_W)) u_slot (
      .Clk      (Clk),
      .Reset    (Reset),
      .flag     (core_flag[g]),
      .v1       (core_val_1[g*DATA_W +: DATA_W]),
      .v2       (core_val_2[g*DATA_W +: DATA_W]),
      .clr      (clr),
      .captured (captured[g]),
      .q1       (slot_q1[g]),
      .q2       (slot_q2[g])
    );
  end

  assign sel_v1 = slot_q1[k_q];
  assign sel_v2 = slot_q2[k_q];
  // Strict compare so an equal value never displaces a lower index.
  assign take   = (k_q == '0) || (sel_v1 < best_v1_q);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    best_v1_d  = best_v1_q;
    best_v2_d  = best_v2_q;
    best_idx_d = best_idx_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (&captured) begin
          state_d = ST_SCAN;
          k_d     = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (take) begin
          best_v1_d  = sel_v1;
          best_v2_d  = sel_v2;
          best_idx_d = k_q;
        end
        if (k_q == LAST_K) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (ack) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      best_v1_q  <= '0;
      best_v2_q  <= '0;
      best_idx_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      best_v1_q  <= best_v1_d;
      best_v2_q  <= best_v2_d;
      best_idx_q <= best_idx_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign best_val_1    = best_v1_q;
  assign best_val_2    = best_v2_q;
  assign best_idx      = best_idx_q;
  assign result_valid  = valid_q;
  assign busy          = busy_q;
  assign captured_mask = captured;

endmodule

// File: tb/tb_child_result_reducer.sv
module tb_child_result_reducer;

  localparam int NC = 31;
  localparam int DW = 32;
  localparam int IW = 5;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [NC-1:0]    core_flag;
  logic [NC*DW-1:0] core_val_1;
  logic [NC*DW-1:0] core_val_2;
  logic             ack;
  logic [DW-1:0]    best_val_1;
  logic [DW-1:0]    best_val_2;
  logic [IW-1:0]    best_idx;
  logic             result_valid;
  logic             busy;
  logic [NC-1:0]    captured_mask;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what each slot should hold for the current round.
  bit          exp_cap [NC];
  logic [31:0] exp_v1  [NC];
  logic [31:0] exp_v2  [NC];

  always #5 Clk = ~Clk;

  child_result_reducer #(.NUM_CORES(NC), .DATA_W(DW), .IDX_W(IW)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .core_flag     (core_flag),
    .core_val_1    (core_val_1),
    .core_val_2    (core_val_2),
    .ack           (ack),
    .best_val_1    (best_val_1),
    .best_val_2    (best_val_2),
    .best_idx      (best_idx),
    .result_valid  (result_valid),
    .busy          (busy),
    .captured_mask (captured_mask)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [NC-1:0] exp_mask();
    logic [NC-1:0] m;
    m = '0;
    for (int i = 0; i < NC; i++) m[i] = exp_cap[i];
    return m;
  endfunction

  // Winner = smallest val_1; among equals, the lowest core index.
  task automatic model_best(output int bi, output logic [31:0] b1, output logic [31:0] b2);
    logic [31:0] mn;
    mn = exp_v1[0];
    for (int i = 1; i < NC; i++) if (exp_v1[i] < mn) mn = exp_v1[i];
    bi = -1;
    for (int i = NC - 1; i >= 0; i--) if (exp_v1[i] == mn) bi = i;
    b1 = mn;
    b2 = exp_v2[bi];
  endtask

  task automatic set_core(input int i, input logic [31:0] a, input logic [31:0] b);
    core_val_1[i*DW +: DW] = a;
    core_val_2[i*DW +: DW] = b;
  endtask

  task automatic gen_val(input int mode, input int i, output logic [31:0] a, output logic [31:0] b);
    case (mode)
      1:       begin a = 32'(100 - i); b = 32'(i * 4); end
      2:       begin a = 32'd5; b = 32'(i); end
      3:       begin a = $urandom_range(0, 7); b = $urandom; end
      4:       begin a = (i == 3) ? 32'd9 : 32'd10 + $urandom_range(0, 1000); b = $urandom; end
      default: begin a = $urandom; b = $urandom; end
    endcase
  endtask

  // Raise every not-yet-captured flag at a random cycle; the last core rises at maxd.
  task automatic capture_phase(input int mode, input int maxd, input int carry, input int last_core);
    int rise_at [NC];
    int last;
    logic [31:0] a, b;
    last = last_core;
    while (last < 0 || last == carry) last = $urandom_range(0, NC - 1);
    for (int i = 0; i < NC; i++) begin
      if (i == carry)     rise_at[i] = -1;
      else if (i == last) rise_at[i] = maxd;
      else                rise_at[i] = (maxd == 0) ? 0 : $urandom_range(0, maxd - 1);
    end
    for (int t = 0; t <= maxd; t++) begin
      for (int i = 0; i < NC; i++) begin
        if (rise_at[i] == t) begin
          gen_val(mode, i, a, b);
          set_core(i, a, b);
          core_flag[i] = 1'b1;
          exp_cap[i] = 1'b1;
          exp_v1[i]  = a;
          exp_v2[i]  = b;
        end else if (rise_at[i] < t && $urandom_range(0, 3) == 0) begin
          core_flag[i] = ~core_flag[i];
          set_core(i, $urandom, $urandom);
        end
      end
      tick();
      chk("capture_mask", 64'(captured_mask), 64'(exp_mask()));
    end
  endtask

  // Entered just after the edge at which the mask became full.
  task automatic finish_round(input int mode, input int carry_next);
    int          bi;
    logic [31:0] b1, b2;
    int          d, r;
    logic [31:0] a, b;
    model_best(bi, b1, b2);
    chk("full_mask", 64'(captured_mask), 64'(exp_mask()));
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_valid", 64'(result_valid), 64'd0);
    for (int j = 1; j <= NC + 1; j++) begin
      r = $urandom_range(0, NC - 1);
      core_flag[r] = ~core_flag[r];
      set_core(r, $urandom, $urandom);
      if (mode == 4 && j == 3) core_flag[3] = 1'b0;
      if (mode == 4 && j == 6) begin
        core_flag[3] = 1'b1;
        set_core(3, 32'd1, $urandom);
      end
      ack = ($urandom_range(0, 4) == 0);
      tick();
      chk("scan_busy", 64'(busy), (j <= NC) ? 64'd1 : 64'd0);
      chk("scan_valid", 64'(result_valid), (j == NC + 1) ? 64'd1 : 64'd0);
    end
    ack = 1'b0;
    chk("best_val_1", 64'(best_val_1), 64'(b1));
    chk("best_val_2", 64'(best_val_2), 64'(b2));
    chk("best_idx", 64'(best_idx), 64'(bi));
    core_flag = '0;
    d = $urandom_range(0, 3);
    for (int j = 0; j < d; j++) begin
      tick();
      chk("done_valid", 64'(result_valid), 64'd1);
      chk("done_hold", 64'(best_val_1), 64'(b1));
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("clear_valid", 64'(result_valid), 64'd1);
    for (int i = 0; i < NC; i++) exp_cap[i] = 1'b0;
    if (carry_next >= 0) begin
      gen_val(0, carry_next, a, b);
      set_core(carry_next, a, b);
      core_flag[carry_next] = 1'b1;
      exp_cap[carry_next] = 1'b1;
      exp_v1[carry_next]  = a;
      exp_v2[carry_next]  = b;
    end
    tick();
    chk("post_valid", 64'(result_valid), 64'd0);
    chk("post_mask", 64'(captured_mask), 64'(exp_mask()));
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_hold_idx", 64'(best_idx), 64'(bi));
    chk("post_hold_v2", 64'(best_val_2), 64'(b2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int carry, nxt;
    logic [31:0] a, b;
    Reset      = 1'b0;
    core_flag  = '0;
    core_val_1 = '0;
    core_val_2 = '0;
    ack        = 1'b0;
    for (int i = 0; i < NC; i++) begin
      exp_cap[i] = 1'b0;
      exp_v1[i]  = '0;
      exp_v2[i]  = '0;
    end
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_best_val_1", 64'(best_val_1), 64'd0);
    chk("rst_best_val_2", 64'(best_val_2), 64'd0);
    chk("rst_best_idx", 64'(best_idx), 64'd0);
    chk("rst_valid", 64'(result_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mask", 64'(captured_mask), 64'd0);
    @(negedge Clk);
    Reset = 1'b1;

    // descending val_1, all flags in one cycle
    capture_phase(1, 0, -1, -1);
    finish_round(1, -1);
    // all val_1 equal
    capture_phase(2, 0, -1, -1);
    finish_round(2, -1);
    // staggered, core 7 last; core 12 rises in the clear cycle
    capture_phase(0, 5, -1, 7);
    finish_round(0, 12);
    capture_phase(0, 4, 12, -1);
    finish_round(0, -1);
    // core 3 holds the minimum and re-pulses during the scan
    capture_phase(4, 3, -1, -1);
    finish_round(4, -1);

    carry = -1;
    for (int r = 0; r < 6; r++) begin
      nxt = (r < 5 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, NC - 1)) : -1;
      capture_phase($urandom_range(0, 3), $urandom_range(0, 6), carry, -1);
      finish_round(0, nxt);
      carry = nxt;
    end

    // reset in the middle of a scan, flags held high across it
    for (int i = 0; i < NC; i++) begin
      gen_val(0, i, a, b);
      set_core(i, a | 32'h1, b);
      core_flag[i] = 1'b1;
      exp_cap[i] = 1'b1;
      exp_v1[i]  = a | 32'h1;
      exp_v2[i]  = b;
    end
    tick();
    chk("pre_rst_mask", 64'(captured_mask), 64'(exp_mask()));
    repeat (16) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk("midscan_best_val_1", 64'(best_val_1), 64'd0);
    chk("midscan_best_val_2", 64'(best_val_2), 64'd0);
    chk("midscan_best_idx", 64'(best_idx), 64'd0);
    chk("midscan_valid", 64'(result_valid), 64'd0);
    chk("midscan_busy", 64'(busy), 64'd0);
    chk("midscan_mask", 64'(captured_mask), 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    finish_round(0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
